pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Program-counter and fetch-control stage. Consumes branch_go / branch_error from
//  the branch resolver and jump requests from decode. Drives the instruction-memory
//  address, flushes the wrong-path fetch on redirect, and traps branch-to-self loops.
//  Sits at the head of the 3-stage pipeline; the branch resolver is directly downstream.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  CNT_W     16             width of the saturating redirect counter
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        asynchronous, active-low reset
//  stall_i        in   1        hazard hold: freeze PC, keep if_valid
//  branch_go      in   1        taken branch, target != own PC
//  branch_error   in   1        taken branch to itself (infinite loop)
//  branch_target  in   32       branch destination
//  jump_go        in   1        unconditional jump from decode
//  jump_target    in   32       jump destination
//  imem_addr      out  32       instruction fetch address (= PC register)
//  pc_plus4       out  32       imem_addr + 4, wraps mod 2^32
//  if_valid       out  1        fetched instruction is on the correct path
//  flush          out  1        kill the instruction in IF/ID this cycle
//  halted         out  1        core trapped
//  trap_pc        out  32       branch_target captured at trap
//  redirect_cnt   out  CNT_W    count of accepted redirects, saturating
// BEHAVIOUR
//  - Reset (async assert, sync release): pc=RESET_PC, state=BOOT, if_valid=0,
//    flush=0, halted=0, trap_pc=0, redirect_cnt=0.
//  - States:
//    BOOT   one cycle with if_valid=0; pc holds; then RUN.
//    RUN    normal fetch.
//    REDIR  one-cycle bubble after a redirect: if_valid=0; pc<=pc+4; then RUN.
//    HALT   terminal; pc frozen; if_valid=0; flush=0; halted=1. Left only by reset.
//  - Priority in RUN (per cycle): branch_error > branch_go > jump_go > stall_i > pc+4.
//  - Redirect (branch_go, or jump_go with no branch): flush=1 combinationally in the
//    same cycle; pc<=target with bits[1:0] forced to 2'b00; state<=REDIR;
//    redirect_cnt+1, holding at all-ones.
//  - A redirect overrides stall_i; with no redirect, stall_i holds pc.
//  - branch_go and branch_error both high: treat as branch_error.
//  - REDIR and BOOT ignore branch/jump inputs; the upstream flush guarantees they are 0.
//  - pc 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000; no flag is raised.
//  - imem_addr/pc_plus4 are registered-PC driven; redirect latency is 1 cycle to
//    the new address and 2 cycles to the first valid instruction.
// CONFIGURATION
//  BRANCH_ERR_TRAP_EN defined:
//    branch_error in RUN: flush=1; trap_pc<=branch_target; state<=HALT.
//    redirect_cnt does not increment.
//  BRANCH_ERR_TRAP_EN undefined:
//    branch_error is handled exactly as branch_go, so the loop executes.
//    HALT is unreachable; halted and trap_pc are tied to 0.
// STRUCTURE
//  - Shared package cpu_pkg: state enum {BOOT,RUN,REDIR,HALT}, PC_STEP=32'd4,
//    XLEN=32, ADDR_ALIGN_MASK=32'hFFFF_FFFC.
//  - One sub-module: sat_counter (parameter W, inc, q) for redirect_cnt.
//  - The next-PC mux and FSM stay in this module.
// TESTING
//  1 Hold rst_n=0, then release -> imem_addr=RESET_PC; if_valid=0 for 1 cycle;
//    then addr 0,4,8 on successive cycles.
//  2 At pc=0x10, branch_go=1, target=0x40 -> flush=1 that cycle; next addr 0x40
//    with if_valid=0; then 0x44 with if_valid=1; redirect_cnt=1.
//  3 stall_i=1 for 3 cycles at pc=0x20 -> addr stays 0x20; with stall_i=1 and
//    jump_go=1, target=0x80 -> addr 0x80 (redirect wins).
//  4 branch_go, jump_go and branch_error all high, target=0x30 -> with the macro:
//    HALT, halted=1, trap_pc=0x30; a later branch_go does nothing; rst_n low -> BOOT.
//    Without the macro: redirect to 0x30.
//  5 pc=0xFFFF_FFF8, run 2 cycles -> addr 0xFFFF_FFFC then 0x0; target=0x43 -> addr 0x40.
//  6 Force redirect_cnt to all-ones, then issue a redirect -> count stays all-ones.
//    Assert rst_n low during REDIR -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states and PC constants.
package cpu_pkg;
  localparam int              XLEN            = 32;
  localparam logic [XLEN-1:0] PC_STEP         = 32'd4;
  localparam logic [XLEN-1:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {BOOT, RUN, REDIR, HALT} fetch_state_e;
endpackage

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Count up once per inc, sticking at the top value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 q <= '0;
    else if (inc && (q != '1)) q <= q + ONE;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control at the head of the pipeline.
// Redirects on branch/jump (one-cycle bubble), holds on stall, and with
// BRANCH_ERR_TRAP_EN defined traps branch-to-self loops into a terminal HALT.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_go,
  input  logic             branch_error,
  input  logic [31:0]      branch_target,
  input  logic             jump_go,
  input  logic [31:0]      jump_target,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc_plus4,
  output logic             if_valid,
  output logic             flush,
  output logic             halted,
  output logic [31:0]      trap_pc,
  output logic [CNT_W-1:0] redirect_cnt
);

  fetch_state_e state, st_nxt;
  logic [31:0]  pc, pc_nxt, tgt;
  logic         redirect, trap;

  // Next-PC mux and next-state; branch_error outranks branch_go outranks jump.
  always_comb begin
    pc_nxt   = pc;
    st_nxt   = state;
    redirect = 1'b0;
    trap     = 1'b0;
    tgt      = branch_target;
    unique case (state)
      BOOT: st_nxt = RUN;
      RUN: begin
        if (branch_error) begin
`ifdef BRANCH_ERR_TRAP_EN
          trap   = 1'b1;
          st_nxt = HALT;
`else
          redirect = 1'b1;
`endif
        end else if (branch_go) begin
          redirect = 1'b1;
        end else if (jump_go) begin
          redirect = 1'b1;
          tgt      = jump_target;
        end else if (!stall_i) begin
          pc_nxt = pc + PC_STEP;
        end
        if (redirect) begin
          pc_nxt = tgt & ADDR_ALIGN_MASK;
          st_nxt = REDIR;
        end
      end
      REDIR: begin
        pc_nxt = pc + PC_STEP;
        st_nxt = RUN;
      end
      default: ;
    endcase
  end

  // FSM state, PC and the registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
    end else begin
      state    <= st_nxt;
      pc       <= pc_nxt;
      if_valid <= (st_nxt == RUN);
    end
  end

`ifdef BRANCH_ERR_TRAP_EN
  logic [31:0] trap_pc_q;
  logic        halted_q;

  // Capture the looping target and raise halted on entry to HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_pc_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      if (trap) trap_pc_q <= branch_target;
      halted_q <= (st_nxt == HALT);
    end
  end

  assign trap_pc = trap_pc_q;
  assign halted  = halted_q;
`else
  assign trap_pc = '0;
  assign halted  = 1'b0;
`endif

  assign imem_addr = pc;
  assign pc_plus4  = pc + PC_STEP;
  assign flush     = redirect | trap;

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect),
    .q     (redirect_cnt)
  );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
// Honors BRANCH_ERR_TRAP_EN the same way the design does.
module tb_pc_fetch_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall_i = 1'b0, branch_go = 1'b0, branch_error = 1'b0, jump_go = 1'b0;
  logic [31:0]   branch_target = '0, jump_target = '0;
  logic [31:0]   imem_addr, pc_plus4, trap_pc;
  logic          if_valid, flush, halted;
  logic [CW-1:0] redirect_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  pc_fetch_ctrl #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .branch_go(branch_go),
    .branch_error(branch_error), .branch_target(branch_target),
    .jump_go(jump_go), .jump_target(jump_target), .imem_addr(imem_addr),
    .pc_plus4(pc_plus4), .if_valid(if_valid), .flush(flush), .halted(halted),
    .trap_pc(trap_pc), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = just out of reset, 1 = fetching,
  // 2 = bubble after redirect, 3 = trapped.
  int          m_mode;
  logic [31:0] m_pc, m_trap;
  int          m_cnt;
  bit          trap_en;

  initial begin
    trap_en = 0;
`ifdef BRANCH_ERR_TRAP_EN
    trap_en = 1;
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = 32'h0; m_trap = 32'h0; m_cnt = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        2: begin m_pc = m_pc + 32'd4; m_mode = 1; end
        1: begin
          if (branch_error && trap_en) begin
            m_trap = branch_target; m_mode = 3;
          end else if (branch_error || branch_go || jump_go) begin
            m_pc = ((branch_error || branch_go) ? branch_target : jump_target) / 4 * 4;
            m_mode = 2;
            if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
          end else if (!stall_i) begin
            m_pc = m_pc + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_mode == 1});
      chk("flush", {31'b0, flush},
          {31'b0, (m_mode == 1) && (branch_go || branch_error || jump_go)});
      chk("halted", {31'b0, halted}, {31'b0, m_mode == 3});
      chk("trap_pc", trap_pc, m_trap);
      chk("redirect_cnt", {28'b0, redirect_cnt}, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    branch_go = 0; branch_error = 0; jump_go = 0; stall_i = 0;
  endtask

  task automatic jump(input logic [31:0] t);
    idle(); jump_go = 1; jump_target = t;
  endtask

  logic [31:0] saved;

  initial begin
    // Test 1: reset and boot
    idle();
    rst_n = 0;
    #1 chk_en = 1;
    repeat (3) tick();
    rst_n = 1;
    chk("boot_addr", imem_addr, 32'h0);
    chk("boot_valid", {31'b0, if_valid}, 32'h0);
    tick(); chk("run_addr0", imem_addr, 32'h0); chk("run_valid", {31'b0, if_valid}, 32'h1);
    tick(); chk("run_addr4", imem_addr, 32'h4);
    tick(); chk("run_addr8", imem_addr, 32'h8);
    tick(); tick(); chk("run_addr10", imem_addr, 32'h10);

    // Test 2: branch at 0x10 to 0x40
    branch_go = 1; branch_target = 32'h40;
    #1 chk("br_flush", {31'b0, flush}, 32'h1);
    tick(); idle();
    chk("br_addr", imem_addr, 32'h40); chk("br_bubble", {31'b0, if_valid}, 32'h0);
    tick();
    chk("br_next", imem_addr, 32'h44); chk("br_valid", {31'b0, if_valid}, 32'h1);
    chk("br_cnt", {28'b0, redirect_cnt}, 32'h1);

    // Test 3: stall at 0x20, then jump overrides stall
    jump(32'h1C); tick(); idle(); tick();
    chk("st_start", imem_addr, 32'h20);
    stall_i = 1;
    repeat (3) begin tick(); chk("st_hold", imem_addr, 32'h20); end
    jump_go = 1; jump_target = 32'h80;
    tick(); idle();
    chk("st_jump", imem_addr, 32'h80);
    tick(); chk("st_after", imem_addr, 32'h84);

    // Test 5: wrap and alignment
    jump(32'hFFFF_FFF4); tick(); idle(); tick();
    chk("wr_f8", imem_addr, 32'hFFFF_FFF8);
    tick(); chk("wr_fc", imem_addr, 32'hFFFF_FFFC);
    chk("wr_p4", pc_plus4, 32'h0);
    tick(); chk("wr_0", imem_addr, 32'h0);
    jump(32'h43); tick(); idle();
    chk("align", imem_addr, 32'h40);
    tick();
    chk("cnt5", {28'b0, redirect_cnt}, 32'h5);

    // Test 4: all three redirects at once
    saved = imem_addr;
    branch_go = 1; branch_error = 1; jump_go = 1;
    branch_target = 32'h30; jump_target = 32'h99;
    tick(); idle();
    if (trap_en) begin
      chk("tr_halted", {31'b0, halted}, 32'h1);
      chk("tr_pc", trap_pc, 32'h30);
      chk("tr_frozen", imem_addr, saved);
      branch_go = 1; branch_target = 32'h50;
      #1 chk("tr_noflush", {31'b0, flush}, 32'h0);
      tick(); idle();
      chk("tr_stay", imem_addr, saved);
      chk("tr_still", {31'b0, halted}, 32'h1);
      rst_n = 0; #1;
      chk("tr_rst_halted", {31'b0, halted}, 32'h0);
      chk("tr_rst_addr", imem_addr, 32'h0);
      tick(); rst_n = 1; tick();
    end else begin
      chk("be_addr", imem_addr, 32'h30);
      chk("be_cnt", {28'b0, redirect_cnt}, 32'h6);
      tick();
    end

    // Test 6: saturation, then reset during bubble
    repeat (18) begin jump(32'h100); tick(); idle(); tick(); end
    chk("sat_top", {28'b0, redirect_cnt}, 32'hF);
    jump(32'h200); tick(); idle();
    chk("sat_hold", {28'b0, redirect_cnt}, 32'hF);
    chk("sat_bubble", {31'b0, if_valid}, 32'h0);
    rst_n = 0; #1;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_cnt", {28'b0, redirect_cnt}, 32'h0);
    chk("rst_trap", trap_pc, 32'h0);
    tick(); rst_n = 1;

    // Randomized traffic checked by the model each cycle
    for (int i = 0; i < 4000; i++) begin
      int r;
      tick();
      if (!rst_n) begin rst_n = 1; continue; end
      r = $urandom_range(0, 99);
      branch_error  = (r < 2);
      branch_go     = (r >= 2 && r < 14) || (r == 0);
      jump_go       = ($urandom_range(0, 9) == 0);
      stall_i       = ($urandom_range(0, 3) == 0);
      branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      jump_target   = $urandom;
      if ($urandom_range(0, 149) == 0) rst_n = 0;
    end
    tick(); idle(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
